// File: rtl/qea_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qea_pkg
// Description : Shared types, lane helpers and constants for the QEA host
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package qea_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LOAD_CTX   = 4'd1,
        ST_LOAD_STATE = 4'd2,
        ST_START      = 4'd3,
        ST_RUN        = 4'd4,
        ST_RD_ISSUE   = 4'd5,
        ST_RD_WAIT    = 4'd6,
        ST_RD_OUT     = 4'd7,
        ST_FIN        = 4'd8
    } qea_state_e;

    // Bit offset of a lane inside a packed multi-lane word.
    function automatic int lane_lsb(input int lane, input int lane_width);
        return lane * lane_width;
    endfunction

    function automatic int top_lane_lsb(input int pe_num, input int lane_width);
        return lane_lsb(pe_num - 1, lane_width);
    endfunction

    // |0...0> amplitude: real part 1.0 in fixed point, imaginary part 0.
    function automatic logic [63:0] ground_amp(input int frac_bits);
        return {32'd1 << frac_bits, 32'd0};
    endfunction

    localparam logic [63:0] c_GROUND_AMP = ground_amp(30);

endpackage
`default_nettype wire

// File: rtl/qea_addr_counter.sv
`default_nettype none
// ============================================================================
// Module      : qea_addr_counter
// Description : Loadable up-counter with a terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module qea_addr_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_last,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_load) begin
            w_count_d = i_load_val;
        end else if (i_inc) begin
            w_count_d = r_count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_count = r_count_q;
    assign o_tc    = (r_count_q == i_last);

endmodule
`default_nettype wire

// File: rtl/qea_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : qea_host_sequencer
// Description : Host-side job sequencer: loads gate context and the initial
//               state vector, starts the QEA, then streams the result out.
// Revision    : 1.0 - initial release
// ============================================================================
module qea_host_sequencer
    import qea_pkg::*;
#(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int RD_LAT                  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_cmd_valid,
    output logic                                 o_cmd_ready,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_cmd_ins_num,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_cmd_qbit_num,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    output logic                                 o_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic [PE_NUM-1:0]                    o_state_ena,
    output logic [PE_NUM-1:0]                    o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    input  logic                                 i_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_res_valid,
    input  logic                                 i_res_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_res_data,
    output logic                                 o_res_last,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_err,
    output logic [31:0]                          o_cycle_count
);

    localparam int TOP_LSB = top_lane_lsb(PE_NUM, STATE_DATA_WIDTH);

    qea_state_e                            r_state_q;
    qea_state_e                            w_state_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]    r_ins_q;
    logic [MAX_QBIT_WIDTH-1:0]             r_qbit_q;
    logic [31:0]                           r_cycle_q;
    logic                                  r_err_q;
    logic                                  r_ctx_en_q;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]    r_ctx_addr_q;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]    r_ctx_data_q;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0]    r_res_data_q;
    logic [7:0]                            r_wait_q;

    logic                                  w_cmd_fire;
    logic                                  w_cmd_ok;
    logic                                  w_accept;
    logic                                  w_ctx_fire;
    logic                                  w_res_fire;
    logic                                  w_rd_cap;
    logic [63:0]                           w_words;
    logic [STATE_ADDR_WIDTH-1:0]           w_state_last;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]    w_ctx_cnt;
    logic                                  w_ctx_tc;
    logic [STATE_ADDR_WIDTH-1:0]           w_wr_cnt;
    logic                                  w_wr_tc;
    logic [STATE_ADDR_WIDTH-1:0]           w_rd_cnt;
    logic                                  w_rd_tc;

    assign w_cmd_fire   = i_cmd_valid && (r_state_q == ST_IDLE);
    assign w_cmd_ok     = (i_cmd_qbit_num > MAX_QBIT_WIDTH'(PE_NUM_WIDTH));
    assign w_accept     = w_cmd_fire && w_cmd_ok;
    assign w_ctx_fire   = i_ctx_valid && (r_state_q == ST_LOAD_CTX);
    assign w_res_fire   = (r_state_q == ST_RD_OUT) && i_res_ready;
    assign w_rd_cap     = (r_state_q == ST_RD_WAIT) && (r_wait_q == 8'(RD_LAT - 1));
    // Each address holds PE_NUM amplitudes, so 2^(qbit - PE_NUM_WIDTH) words.
    assign w_words      = 64'd1 << (r_qbit_q - MAX_QBIT_WIDTH'(PE_NUM_WIDTH));
    assign w_state_last = STATE_ADDR_WIDTH'(w_words - 64'd1);

    qea_addr_counter #(.WIDTH(GATE_CONTEXT_ADDR_WIDTH)) u_ctx_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val ('0),
        .i_inc      (w_ctx_fire),
        .i_last     (r_ins_q - GATE_CONTEXT_ADDR_WIDTH'(1)),
        .o_count    (w_ctx_cnt),
        .o_tc       (w_ctx_tc)
    );

    qea_addr_counter #(.WIDTH(STATE_ADDR_WIDTH)) u_wr_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val ('0),
        .i_inc      (r_state_q == ST_LOAD_STATE),
        .i_last     (w_state_last),
        .o_count    (w_wr_cnt),
        .o_tc       (w_wr_tc)
    );

    qea_addr_counter #(.WIDTH(STATE_ADDR_WIDTH)) u_rd_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val ('0),
        .i_inc      (w_res_fire && !w_rd_tc),
        .i_last     (w_state_last),
        .o_count    (w_rd_cnt),
        .o_tc       (w_rd_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        o_state_ena   = '0;
        o_state_wea   = '0;
        o_state_addra = '0;
        o_state_dina  = '0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_d = (i_cmd_ins_num == '0) ? ST_LOAD_STATE : ST_LOAD_CTX;
                end
            end
            ST_LOAD_CTX: begin
                if (w_ctx_fire && w_ctx_tc) begin
                    w_state_d = ST_LOAD_STATE;
                end
            end
            ST_LOAD_STATE: begin
                o_state_ena   = '1;
                o_state_wea   = '1;
                o_state_addra = w_wr_cnt;
                if (w_wr_cnt == '0) begin
                    o_state_dina[TOP_LSB +: STATE_DATA_WIDTH] =
                        STATE_DATA_WIDTH'(ground_amp(NUM_FRAC_BIT));
                end
                if (w_wr_tc) begin
                    w_state_d = ST_START;
                end
            end
            ST_START: begin
                w_state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_complete) begin
                    w_state_d = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                o_state_ena   = '1;
                o_state_addra = w_rd_cnt;
                w_state_d     = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (w_rd_cap) begin
                    w_state_d = ST_RD_OUT;
                end
            end
            ST_RD_OUT: begin
                if (w_res_fire) begin
                    w_state_d = w_rd_tc ? ST_FIN : ST_RD_ISSUE;
                end
            end
            ST_FIN: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ins_q      <= '0;
            r_qbit_q     <= '0;
            r_cycle_q    <= '0;
            r_err_q      <= 1'b0;
            r_ctx_en_q   <= 1'b0;
            r_ctx_addr_q <= '0;
            r_ctx_data_q <= '0;
            r_res_data_q <= '0;
            r_wait_q     <= '0;
        end else begin
            r_err_q    <= w_cmd_fire && !w_cmd_ok;
            r_ctx_en_q <= w_ctx_fire;
            if (w_accept) begin
                r_ins_q   <= i_cmd_ins_num;
                r_qbit_q  <= i_cmd_qbit_num;
                r_cycle_q <= '0;
            end else if (r_state_q == ST_RUN) begin
                r_cycle_q <= r_cycle_q + 32'd1;
            end
            if (w_ctx_fire) begin
                r_ctx_addr_q <= w_ctx_cnt;
                r_ctx_data_q <= i_ctx_data;
            end
            r_wait_q <= (r_state_q == ST_RD_WAIT) ? r_wait_q + 8'd1 : 8'd0;
            if (w_rd_cap) begin
                r_res_data_q <= i_state_dout;
            end
        end
    end

    assign o_cmd_ready   = (r_state_q == ST_IDLE);
    assign o_ctx_ready   = (r_state_q == ST_LOAD_CTX);
    assign o_start       = (r_state_q == ST_START);
    assign o_busy        = (r_state_q != ST_IDLE);
    assign o_done        = (r_state_q == ST_FIN);
    assign o_err         = r_err_q;
    assign o_qbit_num    = r_qbit_q;
    assign o_cycle_count = r_cycle_q;
    assign o_ctx_en      = r_ctx_en_q;
    assign o_ctx_wea     = r_ctx_en_q;
    assign o_ctx_addr    = r_ctx_addr_q;
    assign o_ctx_data    = r_ctx_data_q;
    assign o_res_valid   = (r_state_q == ST_RD_OUT);
    assign o_res_last    = (r_state_q == ST_RD_OUT) && w_rd_tc;
    assign o_res_data    = r_res_data_q;

endmodule
`default_nettype wire

// File: doc/qea_host_sequencer.md
QEA_HOST_SEQUENCER -- requirements
Module: qea_host_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- PE_NUM_WIDTH, 2, log2 of PE count
- PE_NUM, 4, PE lanes
- STATE_DATA_WIDTH, 64, complex amplitude {re[63:32], im[31:0]}
- STATE_ADDR_WIDTH, 16, state RAM address width
- GATE_CONTEXT_DATA_WIDTH, 64, context word width
- GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width
- MAX_QBIT_WIDTH, 6, qubit-count width
- NUM_FRAC_BIT, 30, fixed-point fraction bits
- RD_LAT, 1, state RAM read latency in cycles

REQ-002 Ports SHALL be (name, direction, width, meaning); one clock, and reset is synchronous and active-high:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- i_cmd_valid / o_cmd_ready  in/out  1  job command handshake
- i_cmd_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  context word count
- i_cmd_qbit_num  in  MAX_QBIT_WIDTH  qubit count
- i_ctx_valid / o_ctx_ready  in/out  1  context word stream handshake
- i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context word
- o_start  out  1  QEA start pulse
- o_qbit_num  out  MAX_QBIT_WIDTH  latched qubit count to QEA
- o_ctx_en, o_ctx_wea  out  1  context RAM enable/write
- o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  context RAM address
- o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  context RAM write data
- o_state_ena, o_state_wea  out  PE_NUM  per-lane state RAM enable/write
- o_state_addra  out  STATE_ADDR_WIDTH  state RAM address
- o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  state RAM write data
- i_complete  in  1  QEA completion level
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  state RAM read data
- o_res_valid / i_res_ready  out/in  1  result stream handshake
- o_res_data  out  PE_NUM*STATE_DATA_WIDTH  result word
- o_res_last  out  1  final result word
- o_busy  out  1  job in progress
- o_done, o_err  out  1  one-cycle status pulses
- o_cycle_count  out  32  execution cycles of the last job

Function
REQ-003 FSM states SHALL be IDLE, LOAD_CTX, LOAD_STATE, START, RUN, RD_ISSUE, RD_WAIT, RD_OUT, FIN.
REQ-004 IDLE SHALL assert o_cmd_ready; on a valid&ready command it SHALL latch ins_num and qbit_num, clear o_cycle_count, and go to LOAD_CTX, or to LOAD_STATE when ins_num==0.
REQ-005 A command with qbit_num <= PE_NUM_WIDTH SHALL be rejected: o_err pulses, state stays IDLE.
REQ-006 LOAD_CTX SHALL assert o_ctx_ready; each accepted word SHALL drive o_ctx_en=o_ctx_wea=1 with o_ctx_addr = 0,1,... and o_ctx_data = word, registered (one cycle later); no write on cycles without a transfer; after ins_num words, go to LOAD_STATE.
REQ-007 LOAD_STATE SHALL write N = 2^(qbit_num-PE_NUM_WIDTH) words, one per cycle, addresses 0..N-1, with all-ones ena/wea.
- word 0: lane PE_NUM-1 (top slice) = {2^NUM_FRAC_BIT, 0}, all other lanes zero
- other words: all zero
REQ-008 START SHALL pulse o_start for exactly one cycle; RUN SHALL increment o_cycle_count each cycle from the cycle after o_start until i_complete is sampled high, then go to RD_ISSUE.
REQ-009 RD_ISSUE SHALL drive ena=all-ones, wea=0, address k for one cycle; RD_WAIT SHALL wait RD_LAT cycles and capture i_state_dout into o_res_data; RD_OUT SHALL hold o_res_valid and the data stable until i_res_ready, then issue k+1.
REQ-010 o_res_last SHALL be high with word N-1; after its transfer go to FIN, pulse o_done, return to IDLE.
REQ-011 o_busy SHALL be high in every state except IDLE; ctx/state write strobes SHALL be zero outside their load states.

Reset
REQ-012 rst sampled high SHALL force IDLE and zero every output (o_qbit_num=0, o_cycle_count=0), aborting any job, including mid-load or mid-readout; no partial strobe SHALL follow.

Structure
REQ-013 A shared package qea_pkg SHALL hold the FSM state enum, the lane slice helpers and the ground-state constant.
REQ-014 The single sub-module SHALL be qea_addr_counter, a loadable up-counter with a terminal-count flag, reused for ctx, state-write and read addresses.

Verification
REQ-015 qbit=7, ins=433 -> ctx writes at 0..432, 32 state writes, word0 top lane=64'h40000000_00000000, one o_start.
REQ-016 i_complete raised 100 cycles after o_start -> o_cycle_count=100, then 32 reads and o_res_last on word 31.
REQ-017 i_res_ready low 5 cycles on word 3 -> o_res_data held stable, no address advance.
REQ-018 qbit=2 -> o_err pulse, o_busy stays 0; ins=0 -> no ctx writes.
REQ-019 rst during LOAD_STATE at word 10 -> all outputs 0 next cycle; a new job completes normally.
